// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/owner types for the memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} e_arb_state;
    typedef enum logic {OWN_FETCH, OWN_DATA} e_arb_owner;
    localparam int WAIT_W = 3;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and RAM signals seen by the memory port arbiter
interface mem_port_arbiter_if #(parameter int AW = 8, parameter int DW = 8);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_ack, f_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter_arb_select.sv
// arb_select: data-first grant with a streak limit that lets a waiting fetch through
module arb_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 3,
    parameter int SW         = $clog2(MAX_STREAK + 1)
) (
    input  logic          f_req,
    input  logic          d_req,
    input  logic          f_mask,
    input  logic          d_mask,
    input  logic [SW-1:0] streak,
    output logic          grant_valid,
    output e_arb_owner    grant_owner
);
    logic f_live;
    logic d_live;
    always_comb begin
        f_live      = f_req && !f_mask;
        d_live      = d_req && !d_mask;
        grant_valid = f_live || d_live;
        grant_owner = (d_live && !(f_live && streak == SW'(MAX_STREAK))) ? OWN_DATA : OWN_FETCH;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync RAM port between fetch and data with IDLE/BUSY/DONE sequencing
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int MEM_WAIT   = 1,
    parameter int MAX_STREAK = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    e_arb_state        state_q, state_d;
    e_arb_owner        owner_q, owner_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              we_q, we_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     f_rdata_q, f_rdata_d;
    logic [DW-1:0]     d_rdata_q, d_rdata_d;
    logic              f_ack_q, f_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              grant_valid;
    e_arb_owner        grant_owner;
    logic              pick_data;

    // The just-acked owner is still lowering its req during DONE, so hide it.
    arb_select #(.MAX_STREAK(MAX_STREAK), .SW(SW)) u_sel (
        .f_req       (bus.f_req),
        .d_req       (bus.d_req),
        .f_mask      (f_ack_q),
        .d_mask      (d_ack_q),
        .streak      (streak_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign pick_data = grant_owner == OWN_DATA;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wait_d    = wait_q;
        streak_d  = streak_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        f_rdata_d = f_ack_q ? bus.mem_rdata : f_rdata_q;
        d_rdata_d = (d_ack_q && !we_q) ? bus.mem_rdata : d_rdata_q;
        if (state_q == ARB_BUSY) begin
            if (wait_q != '0) wait_d = wait_q - WAIT_W'(1);
            else state_d = ARB_DONE;
        end else if (grant_valid) begin
            state_d  = ARB_BUSY;
            owner_d  = grant_owner;
            wait_d   = WAIT_W'(MEM_WAIT);
            addr_d   = pick_data ? bus.d_addr : bus.f_addr;
            we_d     = pick_data && bus.d_we;
            wdata_d  = pick_data ? bus.d_wdata : '0;
            streak_d = !(pick_data && bus.f_req && !f_ack_q) ? '0 :
                       streak_q == SW'(MAX_STREAK) ? streak_q : streak_q + SW'(1);
        end else begin
            state_d = ARB_IDLE;
        end
        mem_en_d = state_d == ARB_BUSY;
        mem_we_d = mem_en_d && we_d;
        busy_d   = state_d != ARB_IDLE;
        f_ack_d  = state_d == ARB_DONE && owner_d == OWN_FETCH;
        d_ack_d  = state_d == ARB_DONE && owner_d == OWN_DATA;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_FETCH;
            wait_q    <= '0;
            streak_q  <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wait_q    <= wait_d;
            streak_q  <= streak_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            f_ack_q   <= f_ack_d;
            d_ack_q   <= d_ack_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.f_ack     = f_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.f_rdata   = f_ack_q ? bus.mem_rdata : f_rdata_q;
    assign bus.d_rdata   = (d_ack_q && !we_q) ? bus.mem_rdata : d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a transaction-level timing model of the shared port
module tb_mem_port_arbiter;
    localparam int MW = 1;
    localparam int MS = 3;

    typedef struct {
        int         at;
        bit         own_d;
        logic [7:0] f_rd;
        logic [7:0] d_rd;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();
    mem_port_arbiter_if #(.AW(8), .DW(8)) bus0 ();

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_WAIT(MW), .MAX_STREAK(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_WAIT(0), .MAX_STREAK(MS)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [256];
    logic [7:0] ram0 [256];
    initial for (int i = 0; i < 256; i++) begin
        ram[i]  = 8'(i ^ 'hA5);
        ram0[i] = 8'(i ^ 'hA5);
    end
    always @(posedge clk) if (bus.mem_en) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end
    always @(posedge clk) if (bus0.mem_en) begin
        if (bus0.mem_we) ram0[bus0.mem_addr] <= bus0.mem_wdata;
        bus0.mem_rdata <= ram0[bus0.mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: every edge where the port is free, apply the select and streak
    // rules to the sampled requests and predict ack cycle, owner and rdata outputs.
    exp_t       sbq[$];
    int         e = 0;
    int         next_free = 0;
    int         streak = 0;
    bit         masked_d = 0;
    bit         fp, dp, gd;
    logic [7:0] shadow [256];
    logic [7:0] f_hold = 0;
    logic [7:0] d_hold = 0;
    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 8'(i ^ 'hA5);
        forever begin
            @(posedge clk);
            e++;
            if (!rst_n) begin
                sbq.delete();
                next_free = 0;
                streak = 0;
                f_hold = 0;
                d_hold = 0;
            end else if (e >= next_free) begin
                fp = bus.f_req && !(e == next_free && !masked_d);
                dp = bus.d_req && !(e == next_free && masked_d);
                if (fp || dp) begin
                    gd = dp && !(fp && streak == MS);
                    streak = (gd && fp) ? ((streak < MS) ? streak + 1 : streak) : 0;
                    if (gd && bus.d_we) shadow[bus.d_addr] = bus.d_wdata;
                    else if (gd) d_hold = shadow[bus.d_addr];
                    else f_hold = shadow[bus.f_addr];
                    sbq.push_back('{e + MW + 1, gd, f_hold, d_hold});
                    next_free = e + MW + 2;
                    masked_d = gd;
                end
            end
        end
    end

    exp_t x;
    initial forever begin
        @(negedge clk);
        if (bus.f_ack || bus.d_ack) begin
            if (sbq.size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                x = sbq.pop_front();
                chk("ack_cycle", e, x.at);
                chk("ack_f", int'(bus.f_ack), int'(!x.own_d));
                chk("ack_d", int'(bus.d_ack), int'(x.own_d));
                chk("f_rdata", int'(bus.f_rdata), int'(x.f_rd));
                chk("d_rdata", int'(bus.d_rdata), int'(x.d_rd));
            end
        end
    end

    task automatic do_fetch(input logic [7:0] a);
        bit got = 0;
        bus.f_req = 1;
        bus.f_addr = a;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            got = bus.f_ack;
        end
        chk("f_timeout", int'(got), 1);
        @(posedge clk); #1;
        bus.f_req = 0;
    endtask

    task automatic do_data(input logic we, input logic [7:0] a, input logic [7:0] wd);
        bit got = 0;
        bus.d_req = 1;
        bus.d_we = we;
        bus.d_addr = a;
        bus.d_wdata = wd;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            got = bus.d_ack;
        end
        chk("d_timeout", int'(got), 1);
        @(posedge clk); #1;
        bus.d_req = 0;
        bus.d_we = 0;
    endtask

    initial begin
        {bus.f_req, bus.d_req, bus.d_we} = '0;
        {bus.f_addr, bus.d_addr, bus.d_wdata} = '0;
        {bus0.f_req, bus0.d_req, bus0.d_we} = '0;
        {bus0.f_addr, bus0.d_addr, bus0.d_wdata} = '0;
        #3;
        chk("rst_mem_en", int'(bus.mem_en), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_acks", int'({bus.f_ack, bus.d_ack}), 0);
        chk("rst_rdata", int'({bus.f_rdata, bus.d_rdata}), 0);
        chk("rst_mem_bus", int'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        bus.f_req = 1; bus.f_addr = 8'h10;
        @(posedge clk); #1;
        chk("t1_en1", int'({bus.mem_en, bus.mem_we, bus.mem_addr}), 'h210);
        chk("t1_ack_early", int'(bus.f_ack), 0);
        @(posedge clk); #1;
        chk("t1_en2", int'({bus.mem_en, bus.mem_addr}), 'h110);
        @(posedge clk); #1;
        chk("t1_ack", int'({bus.f_ack, bus.mem_en}), 2);
        chk("t1_rdata", int'(bus.f_rdata), 'hB5);
        bus.f_req = 0;
        @(posedge clk); #1;
        chk("t1_hold", int'({bus.f_ack, bus.busy, bus.f_rdata}), 'hB5);

        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h20; bus.d_wdata = 8'h3C;
        @(posedge clk); #1;
        chk("t2_we1", int'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 'h1203C);
        @(posedge clk); #1;
        chk("t2_we2", int'({bus.mem_en, bus.mem_we}), 3);
        @(posedge clk); #1;
        chk("t2_ack", int'({bus.d_ack, bus.mem_we}), 2);
        chk("t2_f_rdata", int'(bus.f_rdata), 'hB5);
        bus.d_req = 0; bus.d_we = 0;
        @(posedge clk); #1;
        do_data(0, 8'h20, 8'h00);
        chk("t2_readback", int'(bus.d_rdata), 'h3C);
        chk("t2_f_keep", int'(bus.f_rdata), 'hB5);

        fork
            for (int i = 0; i < 4; i++) do_fetch(8'($urandom));
            for (int i = 0; i < 4; i++) do_data(0, 8'($urandom), 8'h00);
        join

        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                do_fetch(8'($urandom));
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if ($urandom_range(0, 1) == 1) do_data(1, {1'b1, 7'($urandom)}, 8'($urandom));
                else do_data(0, 8'($urandom), 8'h00);
            end
        join

        bus0.f_req = 1; bus0.f_addr = 8'h5A;
        @(posedge clk); #1;
        chk("t6_busy", int'({bus0.mem_en, bus0.f_ack, bus0.mem_addr}), 'h25A);
        @(posedge clk); #1;
        chk("t6_ack", int'({bus0.f_ack, bus0.f_rdata}), 'h1FF);
        bus0.f_req = 0;
        @(posedge clk); #1;
        chk("t6_hold", int'({bus0.f_ack, bus0.f_rdata}), 'hFF);

        repeat (3) begin @(posedge clk); #1; end
        bus.f_req = 1; bus.f_addr = 8'h44;
        @(posedge clk); #1;
        chk("t5_busy", int'(bus.mem_en), 1);
        rst_n = 0;
        #1;
        chk("t5_rst_out", int'({bus.mem_en, bus.busy, bus.f_ack, bus.d_ack}), 0);
        chk("t5_rst_rdata", int'({bus.f_rdata, bus.d_rdata}), 0);
        bus.f_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        do_fetch(8'h44);
        chk("t5_refetch", int'(bus.f_rdata), 'hE1);

        repeat (10) @(posedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
